// File: rtl/i2d_if_pkg.sv
// Types and constants for the i2d_if fetch stage. Values mirror i2d_defines.v;
// the guarded fallbacks let the package compile whichever file is read first.
`ifndef I2D_RESET_VECTOR
`define I2D_RESET_VECTOR 32'h0
`endif
`ifndef I2D_NOP
`define I2D_NOP 32'h0
`endif
`ifndef I2D_ST_FETCH
`define I2D_ST_FETCH 2'd0
`define I2D_ST_HOLD  2'd1
`define I2D_ST_FLUSH 2'd2
`define I2D_ST_ERR   2'd3
`endif

package i2d_if_pkg;

    localparam logic [31:0] RESET_VECTOR = `I2D_RESET_VECTOR;
    localparam logic [31:0] NOP_WORD     = `I2D_NOP;
    localparam int          BUF_W        = 64;

    typedef enum logic [1:0] {
        ST_FETCH = `I2D_ST_FETCH,
        ST_HOLD  = `I2D_ST_HOLD,
        ST_FLUSH = `I2D_ST_FLUSH
`ifdef I2D_IF_ALIGN_CHK_EN
        , ST_ERR = `I2D_ST_ERR
`endif
    } i2d_state_e;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/i2d_if_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
// Handshake: imem_req stays high with imem_addr stable until a cycle in which
// imem_ack=1; imem_rdata is valid in that same cycle. An ack with req low is ignored.
interface i2d_if_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/i2d_defines.v
// Shared constants for the instruction fetch stage: reset vector, bubble word
// and FSM state encodings.
`ifndef I2D_DEFINES_V
`define I2D_DEFINES_V
`ifndef I2D_RESET_VECTOR
`define I2D_RESET_VECTOR 32'h0
`endif
`ifndef I2D_NOP
`define I2D_NOP 32'h0
`endif
`ifndef I2D_ST_FETCH
`define I2D_ST_FETCH 2'd0
`define I2D_ST_HOLD  2'd1
`define I2D_ST_FLUSH 2'd2
`define I2D_ST_ERR   2'd3
`endif
`endif

// File: rtl/i2d_if_buf.sv
// One-entry hold register for a fetched {instruction, pc} pair while decode stalls.
module i2d_if_buf
    import i2d_if_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_unload,
    input  logic             i_clear,
    input  logic [BUF_W-1:0] i_data,
    output logic [BUF_W-1:0] o_data,
    output logic             o_full
);

    logic [BUF_W-1:0] r_data;
    logic             r_full;

    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/i2d_if.sv
// Instruction fetch stage: issues word fetches, registers them toward decode,
// parks one word while decode stalls, and handles branch redirects.
// Optional misaligned-branch trap enabled by defining I2D_IF_ALIGN_CHK_EN.
module i2d_if
    import i2d_if_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    i2d_if_if.master        imem,
    input  logic            i_if_stall,
    input  logic            i_branch,
    input  logic [31:0]     i_branch_target,
    output logic [31:0]     o_if_ins,
    output logic [31:0]     o_if_pc,
    output logic            o_if_valid,
    output logic            o_if_err,
    output i2d_state_e      o_state
);

    i2d_state_e  r_state, w_state_nxt;
    logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0] r_flush_addr, w_flush_addr_nxt;
    logic [31:0] r_ins, w_ins_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_err, w_err_nxt;

    logic             w_req, w_ack, w_out_free;
    logic [31:0]      w_tgt;
    logic             w_misalign;
    i2d_state_e       w_redirect_state;
    logic             w_buf_load, w_buf_unload, w_buf_clear, w_buf_full;
    logic [BUF_W-1:0] w_buf_out;

`ifdef I2D_IF_ALIGN_CHK_EN
    assign w_tgt      = i_branch_target;
    assign w_misalign = |i_branch_target[1:0];
`else
    assign w_tgt      = i_branch_target & ~32'h3;
    assign w_misalign = 1'b0;
`endif

    // Request is gated by rst so it drops immediately and reappears in the first cycle out of reset.
    assign w_req       = rst && (r_state == ST_FETCH || r_state == ST_FLUSH);
    assign w_ack       = imem.imem_ack && w_req;
    assign w_out_free  = !r_valid || !i_if_stall;
    assign imem.imem_req  = w_req;
    assign imem.imem_addr = !w_req ? 32'h0 :
                            (r_state == ST_FLUSH) ? r_flush_addr : r_fetch_pc;

    i2d_if_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_buf_load),
        .i_unload (w_buf_unload),
        .i_clear  (w_buf_clear),
        .i_data   ({imem.imem_rdata, r_fetch_pc}),
        .o_data   (w_buf_out),
        .o_full   (w_buf_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_FETCH;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_flush_addr_nxt = r_flush_addr;
        w_ins_nxt        = r_ins;
        w_pc_nxt         = r_pc;
        w_valid_nxt      = r_valid;
        w_err_nxt        = r_err;
        w_buf_load       = 1'b0;
        w_buf_unload     = 1'b0;
        w_buf_clear      = 1'b0;
        w_redirect_state = ST_FETCH;
`ifdef I2D_IF_ALIGN_CHK_EN
        if (w_misalign) w_redirect_state = ST_ERR;
`endif
        case (r_state)
            ST_FETCH: begin
                if (i_branch) begin
                    w_valid_nxt    = 1'b0;
                    w_fetch_pc_nxt = w_tgt;
                    w_err_nxt      = w_misalign;
                    if (w_ack) begin
                        w_state_nxt = w_redirect_state;
                    end else begin
                        // The old request must still complete; its data is dropped in FLUSH.
                        w_state_nxt      = ST_FLUSH;
                        w_flush_addr_nxt = r_fetch_pc;
                    end
                end else if (w_ack) begin
                    w_fetch_pc_nxt = next_pc(r_fetch_pc);
                    if (w_out_free) begin
                        w_ins_nxt   = imem.imem_rdata;
                        w_pc_nxt    = r_fetch_pc;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (!i_if_stall) begin
                    w_valid_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (i_branch) begin
                    w_buf_clear    = 1'b1;
                    w_valid_nxt    = 1'b0;
                    w_fetch_pc_nxt = w_tgt;
                    w_err_nxt      = w_misalign;
                    w_state_nxt    = w_redirect_state;
                end else if (!i_if_stall && w_buf_full) begin
                    w_ins_nxt    = w_buf_out[63:32];
                    w_pc_nxt     = w_buf_out[31:0];
                    w_valid_nxt  = 1'b1;
                    w_buf_unload = 1'b1;
                    w_state_nxt  = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                w_valid_nxt = 1'b0;
                if (i_branch) begin
                    w_fetch_pc_nxt = w_tgt;
                    w_err_nxt      = w_misalign;
                end
                if (w_ack) begin
                    w_state_nxt = ST_FETCH;
`ifdef I2D_IF_ALIGN_CHK_EN
                    if (w_err_nxt) w_state_nxt = ST_ERR;
`endif
                end
            end
`ifdef I2D_IF_ALIGN_CHK_EN
            ST_ERR: begin
                w_valid_nxt = 1'b0;
                if (i_branch) begin
                    w_fetch_pc_nxt = w_tgt;
                    w_err_nxt      = w_misalign;
                    w_state_nxt    = w_redirect_state;
                end
            end
`endif
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc   <= RESET_VECTOR;
            r_flush_addr <= 32'h0;
            r_ins        <= NOP_WORD;
            r_pc         <= 32'h0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_flush_addr <= w_flush_addr_nxt;
            r_ins        <= w_ins_nxt;
            r_pc         <= w_pc_nxt;
            r_valid      <= w_valid_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign o_if_ins   = r_ins;
    assign o_if_pc    = r_pc;
    assign o_if_valid = r_valid;
`ifdef I2D_IF_ALIGN_CHK_EN
    assign o_if_err   = r_err;
`else
    assign o_if_err   = 1'b0;
`endif
    assign o_state    = r_state;

endmodule

// File: doc/i2d_if.md
I2D_IF -- requirements
Module: i2d_if

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low.
REQ-003 imem_req  output  1  instruction memory request; held high until imem_ack.
REQ-004 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-005 imem_ack  input  1  single-cycle acknowledge; imem_rdata valid in the same cycle.
REQ-006 imem_rdata  input  32  fetched instruction word.
REQ-007 if_stall  input  1  decode stage not accepting; output register SHALL hold.
REQ-008 branch  input  1  redirect request, one cycle.
REQ-009 branch_target  input  32  redirect address, sampled when branch=1.
REQ-010 if_ins  output  32  instruction to decode, registered.
REQ-011 if_pc  output  32  address of if_ins, registered.
REQ-012 if_valid  output  1  if_ins/if_pc hold a live instruction.
REQ-013 if_err  output  1  misaligned redirect flag, registered.

Function
REQ-014 The FSM SHALL have states FETCH, HOLD, FLUSH and, with I2D_IF_ALIGN_CHK_EN, ERR.
REQ-015 FETCH: imem_req=1, imem_addr=fetch_pc; on imem_ack with output free (if_valid=0 or if_stall=0), load if_ins<=imem_rdata, if_pc<=fetch_pc, if_valid<=1, fetch_pc<=fetch_pc+4 (mod 2^32, wraps to 0).
REQ-016 Latency: ack in cycle N SHALL give if_valid=1 in cycle N+1; with ack every cycle, throughput SHALL be one instruction per cycle.
REQ-017 FETCH, ack while if_valid=1 and if_stall=1: store word and address in the hold register, fetch_pc+=4, go to HOLD.
REQ-018 HOLD: imem_req=0; when if_stall=0, move the hold register to the outputs (if_valid=1) and go to FETCH.
REQ-019 When if_stall=0 and no new word is loaded, if_valid SHALL go to 0 in the next cycle.
REQ-020 When branch=1, fetch_pc<=branch_target and if_valid<=0 in the next cycle; branch SHALL take priority over if_stall.
REQ-021 Branch in FETCH with no ack that cycle: go to FLUSH; keep imem_req=1 at the old address until ack; discard the data; then go to FETCH at the new fetch_pc.
REQ-022 Branch in the same cycle as ack: discard the acked word; go to FETCH at branch_target.
REQ-023 Branch in HOLD: discard the hold register; go to FETCH.
REQ-024 Branch in FLUSH: update fetch_pc only; remain in FLUSH until the outstanding ack.

Reset
REQ-025 While rst=0: if_ins=0, if_pc=0, if_valid=0, if_err=0, imem_req=0, imem_addr=0, hold register cleared, state=FETCH, fetch_pc=`I2D_RESET_VECTOR.
REQ-026 Reset with a request outstanding SHALL abandon that request; a stale ack arriving during reset SHALL be ignored.
REQ-027 First request after rst rises: imem_req=1 at `I2D_RESET_VECTOR in the first cycle with rst=1.

Configuration
REQ-028 Macro I2D_IF_ALIGN_CHK_EN defined: a branch with branch_target[1:0]!=0 SHALL set if_err=1 and if_valid=0 and enter ERR (imem_req=0), or FLUSH-then-ERR if a request is outstanding; ERR is left only on an aligned branch, which clears if_err.
REQ-029 Macro not defined: branch_target[1:0] SHALL be forced to 00 and if_err tied to 0; no ERR state.

Structure
REQ-030 `I2D_RESET_VECTOR (32'h0), `I2D_NOP (32'h0) and the state encodings SHALL live in i2d_defines.v.
REQ-031 The hold register SHALL be a sub-module i2d_if_buf: one-entry, 64-bit data, load/unload/clear ports.

Verification
REQ-032 Reset released with ack every cycle -> imem_addr 0,4,8,12; if_pc 0,4,8 from the cycle after each ack.
REQ-033 if_stall=1 at if_pc=8 with ack at addr 12 -> HOLD, imem_req=0, if_pc stays 8; stall drops -> if_pc=12 next cycle, fetch resumes at 16.
REQ-034 branch=1, target 32'h100, request to 0x20 unacked -> FLUSH, 0x20 data discarded after ack, next imem_addr=0x100, if_valid=0 meanwhile.
REQ-035 branch and ack in the same cycle, target 0x40 -> acked word never appears; if_pc=0x40 after the next ack.
REQ-036 With the macro, target 0x102 -> if_err=1, imem_req=0; aligned branch to 0x200 -> if_err=0, fetch at 0x200; without the macro, 0x102 fetches 0x100.
REQ-037 rst=0 asserted mid-HOLD -> all outputs zero next cycle; fetch restarts at 0.
